// File: rtl/banked_ram_top.sv
// banked_ram_top: 256 x 32 single-port synchronous RAM built from four 64-word banks, registered read.
// Define RAM_BANK_DEBUG_EN to expose the registered one-hot bank select on bank_sel.
module banked_ram_top #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int BANK_BITS = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_W-1:0]         Address,
    input  logic                      Write,
    input  logic [DATA_W-1:0]         In,
`ifdef RAM_BANK_DEBUG_EN
    output logic [(2**BANK_BITS)-1:0] bank_sel,
`endif
    output logic [DATA_W-1:0]         Dout
);
    localparam int NBANKS     = 2**BANK_BITS;
    localparam int WORD_W     = ADDR_W - BANK_BITS;
    localparam int BANK_DEPTH = 2**WORD_W;

    logic [BANK_BITS-1:0] bank_idx;
    logic [WORD_W-1:0]    word_idx;
    logic [NBANKS-1:0]    bank_en;
    logic                 wr_req;
    logic [DATA_W-1:0]    bank_rdata [NBANKS];

    assign bank_idx = Address[ADDR_W-1 -: BANK_BITS];
    assign word_idx = Address[WORD_W-1:0];

    // Only a definite 1 on Write counts as a write; X or 0 behaves as a read.
    assign wr_req = (Write === 1'b1);

    always_comb begin
        bank_en           = '0;
        bank_en[bank_idx] = 1'b1;
    end

    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        // 2-state storage starts at zero at time 0; reset never touches it.
        bit [DATA_W-1:0] mem [BANK_DEPTH];

        always_ff @(posedge clk) begin
            if (!rst && wr_req && bank_en[b])
                mem[word_idx] <= In;
        end

        assign bank_rdata[b] = mem[word_idx];
    end

    always_ff @(posedge clk) begin
        if (rst)
            Dout <= '0;
        else if (!wr_req)
            Dout <= bank_rdata[bank_idx];
    end

`ifdef RAM_BANK_DEBUG_EN
    always_ff @(posedge clk) begin
        if (rst)
            bank_sel <= '0;
        else
            bank_sel <= bank_en;
    end
`endif

endmodule

// File: tb/tb_banked_ram_top.sv
// Self-checking bench for banked_ram_top: directed vector table, burst sequence, randomized ops vs a flat-array model.
// Build with RAM_BANK_DEBUG_EN defined to also check bank_sel.
module tb_banked_ram_top;
    logic        clk = 1'b0;
    logic        rst;
    logic        Write;
    logic [7:0]  Address;
    logic [31:0] In;
    logic [31:0] Dout;
`ifdef RAM_BANK_DEBUG_EN
    logic [3:0]  bank_sel;
    logic [3:0]  ref_sel;
`endif

    banked_ram_top dut (
        .clk     (clk),
        .rst     (rst),
        .Address (Address),
        .Write   (Write),
        .In      (In),
`ifdef RAM_BANK_DEBUG_EN
        .bank_sel(bank_sel),
`endif
        .Dout    (Dout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        w;
        logic [7:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
        logic [3:0]  sel;
        string       name;
    } vec_t;

    vec_t        vq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] ref_mem [256];
    logic [31:0] ref_dout;
    logic [7:0]  pool [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic w, input logic [7:0] a, input logic [31:0] d,
                       input logic [31:0] exp, input logic [3:0] sel, input string name);
        vec_t v;
        v.r = r; v.w = w; v.a = a; v.d = d; v.exp = exp; v.sel = sel; v.name = name;
        vq.push_back(v);
    endtask

    // Drive one operation, let one rising edge sample it, update the model, sample 1 time unit later.
    task automatic step(input logic r, input logic w, input logic [7:0] a, input logic [31:0] d);
        rst = r; Write = w; Address = a; In = d;
        @(posedge clk);
        if (r) begin
            ref_dout = '0;
`ifdef RAM_BANK_DEBUG_EN
            ref_sel = '0;
`endif
        end else begin
`ifdef RAM_BANK_DEBUG_EN
            ref_sel = 4'b0001 << a[7:6];
`endif
            if (w) ref_mem[a] = d;
            else   ref_dout   = ref_mem[a];
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        ref_dout = '0;
        pool = '{8'h00, 8'h3F, 8'h40, 8'h7F, 8'h80, 8'hBF, 8'hC0, 8'hFF, 8'h0B, 8'h4B};
        rst = 1'b1; Write = 1'b0; Address = '0; In = '0;

        //   r  w  addr   data          Dout expected  bank_sel  name
        add(1, 1, 8'h4B, 32'hAA,       32'd0,         4'b0000, "rst_write_0");
        add(1, 1, 8'h4B, 32'hAA,       32'd0,         4'b0000, "rst_write_1");
        add(0, 0, 8'h4B, 32'h0,        32'd0,         4'b0010, "rd_after_rst_suppressed");
        add(0, 1, 8'h4B, 32'd12,       32'd0,         4'b0010, "wr12_dout_holds");
        add(0, 0, 8'h4B, 32'h0,        32'd12,        4'b0010, "rd_4b_12");
        add(0, 0, 8'h4B, 32'd15,       32'd12,        4'b0010, "rd_in15_no_write");
        add(0, 1, 8'h4B, 32'd15,       32'd12,        4'b0010, "wr15_dout_holds");
        add(0, 0, 8'h4B, 32'h0,        32'd15,        4'b0010, "rd_4b_15");
        add(0, 1, 8'h83, 32'd20,       32'd15,        4'b0100, "wr_83");
        add(0, 1, 8'hC3, 32'd20,       32'd15,        4'b1000, "wr_c3");
        add(0, 0, 8'h4B, 32'h0,        32'd15,        4'b0010, "iso_rd_4b");
        add(0, 0, 8'h83, 32'h0,        32'd20,        4'b0100, "iso_rd_83");
        add(0, 0, 8'hC3, 32'h0,        32'd20,        4'b1000, "iso_rd_c3");
        add(0, 0, 8'h0B, 32'h0,        32'd0,         4'b0001, "rd_0b_unwritten");
        add(0, 1, 8'h0B, 32'd7,        32'd0,         4'b0001, "wr_0b_7");
        add(0, 0, 8'h4B, 32'h0,        32'd15,        4'b0010, "rd_4b_after_0b");
        add(0, 0, 8'h0B, 32'h0,        32'd7,         4'b0001, "rd_0b_7");
        add(0, 1, 8'h0B, 32'd7,        32'd7,         4'b0001, "wr_same_data");
        add(0, 0, 8'h0B, 32'h0,        32'd7,         4'b0001, "rd_same_data");
        add(1, 0, 8'h0B, 32'h0,        32'd0,         4'b0000, "mid_rst_clears_dout");
        add(1, 1, 8'h0B, 32'd99,       32'd0,         4'b0000, "mid_rst_write");
        add(0, 0, 8'h0B, 32'h0,        32'd7,         4'b0001, "contents_kept_over_rst");
        add(0, 1, 8'hFF, 32'hFFFFFFFF, 32'd7,         4'b1000, "wr_ff");
        add(0, 0, 8'hFF, 32'h0,        32'hFFFFFFFF,  4'b1000, "rd_ff");
        add(0, 0, 8'h00, 32'h0,        32'd0,         4'b0001, "rd_00");
        add(0, 0, 8'h3F, 32'h0,        32'd0,         4'b0001, "rd_3f");
        add(0, 1, 8'h40, 32'hDEADBEEF, 32'd0,         4'b0010, "wr_40");
        add(0, 0, 8'h40, 32'h0,        32'hDEADBEEF,  4'b0010, "rd_40");
        add(0, 0, 8'h3F, 32'h0,        32'd0,         4'b0001, "rd_3f_no_alias");

        foreach (vq[i]) begin
            step(vq[i].r, vq[i].w, vq[i].a, vq[i].d);
            check(vq[i].name, Dout, vq[i].exp);
`ifdef RAM_BANK_DEBUG_EN
            check({vq[i].name, "_sel"}, {28'd0, bank_sel}, {28'd0, vq[i].sel});
`endif
        end

        // Back-to-back burst: eight writes spread over all banks, then eight reads every cycle.
        for (int i = 0; i < 8; i++) begin
            logic [7:0] a;
            a = {i[1:0], 6'(i * 5)};
            step(0, 1, a, 32'h1000 + 32'(i));
        end
        for (int i = 0; i < 8; i++) begin
            logic [7:0] a;
            a = {i[1:0], 6'(i * 5)};
            step(0, 0, a, 32'h0);
            check("burst_rd", Dout, 32'h1000 + 32'(i));
        end

        for (int n = 0; n < 600; n++) begin
            logic        r;
            logic        w;
            logic [7:0]  a;
            logic [31:0] d;
            r = ($urandom_range(0, 31) == 0);
            w = $urandom_range(0, 1) == 1;
            a = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 9)] : 8'($urandom_range(0, 255));
            d = $urandom;
            step(r, w, a, d);
            check("rand_dout", Dout, ref_dout);
`ifdef RAM_BANK_DEBUG_EN
            check("rand_sel", {28'd0, bank_sel}, {28'd0, ref_sel});
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
